data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder: the memory side of the CPU's load/store interface (mem_read / mem_write / address / write data / funct3).
- Accepts one request at a time through a valid/ready handshake.
- Waits a fixed, parameterised latency, then returns load data or a store completion as a one-cycle response pulse.
- Sits between the datapath's memory stage and the word-addressed data array. Later multi-cycle and pipelined cores stall on its `is_ready` / `resp_valid`.

---
 rtl/data_mem_responder_pkg.sv | 24 ++
 rtl/data_mem_responder_lane_align.sv | 47 ++++
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 access codes and FSM states.
package data_mem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_BUSY = 2'd1,
    RESP_RESP = 2'd2
  } resp_state_t;

  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load) return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    else         return f3 inside {F3_SB, F3_SH, F3_SW};
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Combinational byte-lane logic: load extraction/extension, store merge, alignment check.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  output logic [31:0] ld_val,
  output logic [31:0] wr_word,
  output logic        align_err
);

  logic [4:0]  sh;
  logic [15:0] sh_rd;
  logic [31:0] mask;

  assign sh    = {byte_off, 3'b000};
  assign sh_rd = 16'(rd_word >> sh);

  always_comb begin
    ld_val = '0;
    case (funct3)
      F3_LB:   ld_val = {{24{sh_rd[7]}}, sh_rd[7:0]};
      F3_LH:   ld_val = {{16{sh_rd[15]}}, sh_rd};
      F3_LW:   ld_val = rd_word;
      F3_LBU:  ld_val = {24'h0, sh_rd[7:0]};
      F3_LHU:  ld_val = {16'h0, sh_rd};
      default: ld_val = '0;
    endcase
  end

  // Only the addressed lanes take store data; the rest of the word is preserved.
  always_comb begin
    mask = '1;
    case (funct3[1:0])
      2'b00:   mask = 32'h0000_00FF << sh;
      2'b01:   mask = 32'h0000_FFFF << sh;
      default: mask = '1;
    endcase
    wr_word = (rd_word & ~mask) | ((st_data << sh) & mask);
  end

  assign align_err = ((funct3[1:0] == 2'b01) && byte_off[0]) ||
                     ((funct3[1:0] == 2'b10) && (byte_off != 2'b00));

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed LATENCY, one-cycle response pulse.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int NUM_WORDS = 16384,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        is_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] din,
  output logic        resp_valid,
  output logic [31:0] dout,
  output logic        resp_error
);

  localparam int          AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [31:0] NW = 32'(NUM_WORDS);

  resp_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, enter_resp;

  logic [31:0] lat_addr, lat_din;
  logic [2:0]  lat_f3;
  logic        lat_rd, lat_wr;

  logic [31:0] mem [0:NUM_WORDS-1];

  // With LATENCY==1 the response is produced on the accept edge, so the
  // request fields come straight from the ports while IDLE.
  logic [31:0] cur_addr, cur_din;
  logic [2:0]  cur_f3;
  logic        cur_rd, cur_wr, cur_err;
  logic [AW-1:0] idx;
  logic [31:0] rd_word, ld_val, wr_word;
  logic        align_err;

  assign cur_addr = (state == RESP_IDLE) ? addr      : lat_addr;
  assign cur_din  = (state == RESP_IDLE) ? din       : lat_din;
  assign cur_f3   = (state == RESP_IDLE) ? funct3    : lat_f3;
  assign cur_rd   = (state == RESP_IDLE) ? mem_read  : lat_rd;
  assign cur_wr   = (state == RESP_IDLE) ? mem_write : lat_wr;

  assign idx     = cur_addr[AW+1:2];
  assign rd_word = mem[idx];

  mem_lane_align u_align (
    .byte_off (cur_addr[1:0]),
    .funct3   (cur_f3),
    .rd_word  (rd_word),
    .st_data  (cur_din),
    .ld_val   (ld_val),
    .wr_word  (wr_word),
    .align_err(align_err)
  );

  assign cur_err = align_err
                || ({2'b00, cur_addr[31:2]} >= NW)
                || !f3_legal(cur_rd, cur_f3)
                || (cur_rd == cur_wr);

  assign is_ready = reset && (state == RESP_IDLE);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      RESP_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_nxt = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_nxt  = RESP_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = RESP_BUSY;
          end
        end
      end
      RESP_BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP_RESP: state_nxt = RESP_IDLE;
      default:   state_nxt = RESP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RESP_IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      dout       <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      resp_valid <= enter_resp;
      resp_error <= enter_resp && cur_err;
      dout       <= (enter_resp && cur_rd && !cur_err) ? ld_val : '0;
      if (accept) begin
        lat_addr <= addr;
        lat_din  <= din;
        lat_f3   <= funct3;
        lat_rd   <= mem_read;
        lat_wr   <= mem_write;
      end
    end
  end

  // Array is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && cur_wr && !cur_err)
      mem[idx] <= wr_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expectations queued at accept, checked on resp_valid.
module tb_data_mem_responder;

  localparam int NUM_WORDS = 16384;
  localparam int LATENCY   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        is_ready;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] din = '0;
  logic        resp_valid;
  logic [31:0] dout;
  logic        resp_error;

  data_mem_responder #(.NUM_WORDS(NUM_WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .is_ready(is_ready),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .funct3(funct3),
    .din(din), .resp_valid(resp_valid), .dout(dout), .resp_error(resp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on each pulse; outputs must be zero otherwise.
  always @(posedge clk) begin
    #1;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_resp", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("latency", 32'(cyc - e.acc), 32'(LATENCY));
        chk("dout", dout, e.dout);
        chk("resp_error", 32'(resp_error), 32'(e.err));
      end
    end else begin
      chk("quiet_outputs", {dout[30:0], resp_error}, 32'd0);
    end
  end

  task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [2:0] f3, input logic [31:0] d,
                     input logic [31:0] exp_dout, input logic exp_err);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!is_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!is_ready) chk("ready_timeout", 32'(is_ready), 32'd1);
    mem_read = rd; mem_write = wr; addr = a; funct3 = f3; din = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    e.dout = exp_dout; e.err = exp_err; e.acc = cyc;
    exp_q.push_back(e);
    req_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held with a request pending
    mem_write = 1'b1; addr = 32'h20; funct3 = 3'b010; din = 32'h1111_1111;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_ready", 32'(is_ready), 32'd0);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_dout", dout, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; mem_write = 1'b0; reset = 1'b1;
    #1;
    chk("ready_after_rst", 32'(is_ready), 32'd1);

    // 2: word store then load
    req(1'b0, 1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    req(1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // 3: sub-word loads with sign/zero extension
    req(1'b1, 1'b0, 32'h13, 3'b000, 32'h0, 32'hFFFF_FFDE, 1'b0);
    req(1'b1, 1'b0, 32'h13, 3'b100, 32'h0, 32'h0000_00DE, 1'b0);
    req(1'b1, 1'b0, 32'h12, 3'b001, 32'h0, 32'hFFFF_DEAD, 1'b0);
    req(1'b1, 1'b0, 32'h12, 3'b101, 32'h0, 32'h0000_DEAD, 1'b0);

    // 4: byte and half stores merge into the word
    req(1'b0, 1'b1, 32'h11, 3'b000, 32'h1234_5655, 32'h0, 1'b0);
    req(1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 32'hDEAD_55EF, 1'b0);
    req(1'b0, 1'b1, 32'h12, 3'b001, 32'h0000_AAAA, 32'h0, 1'b0);
    req(1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 32'hAAAA_55EF, 1'b0);

    // 5: error responses
    req(1'b1, 1'b0, 32'h12, 3'b010, 32'h0, 32'h0, 1'b1);
    req(1'b0, 1'b1, 32'h12, 3'b010, 32'h5555_5555, 32'h0, 1'b1);
    req(1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 32'hAAAA_55EF, 1'b0);
    req(1'b1, 1'b1, 32'h10, 3'b010, 32'h0, 32'h0, 1'b1);
    req(1'b1, 1'b0, 32'(4 * NUM_WORDS), 3'b010, 32'h0, 32'h0, 1'b1);
    req(1'b1, 1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
    req(1'b0, 1'b1, 32'h10, 3'b100, 32'h0, 32'h0, 1'b1);
    req(1'b1, 1'b0, 32'h11, 3'b101, 32'h0, 32'h0, 1'b1);

    // 6: request during BUSY is ignored; reset during BUSY abandons the store
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; addr = 32'h10; funct3 = 3'b010; din = 32'h0;
    req_valid = 1'b1;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0;
    #1;
    chk("busy_ready", 32'(is_ready), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_busy_ready", 32'(is_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (LATENCY + 3) @(negedge clk);
    req(1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 32'hAAAA_55EF, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
